sdram_wb_arb: RTL and testbench
===============================

// Module: sdram_wb_arb
// PURPOSE
//   Parametrised multi-master Wishbone front end for the SDRAM controller. It
//   arbitrates NCH Wishbone slave ports round-robin onto the single
//   sdram_addr/wr/rd/op_done command interface of sdram_ctrl. It replaces the
//   single-port sdram_wb in sdram_top, with generic address and data widths.
// PARAMETERS
//   NCH     4   number of Wishbone slave channels (1..16)
//   AW      32  address width per channel
//   DW      16  data width (equals SDRAM dq width)
//   TIMEOUT 256 cycles allowed for op_done; used only with SDRAM_ARB_TIMEOUT_EN
// PORTS
//   clk            in   1       system clock
//   reset_n        in   1       reset, asynchronous, active-low
//   wbs_address    in   NCH*AW  per-channel address, channel i at [i*AW +: AW]
//   wbs_writedata  in   NCH*DW  per-channel write data
//   wbs_readdata   out  NCH*DW  per-channel read data, valid with ack
//   wbs_strobe     in   NCH     per-channel strobe
//   wbs_cycle      in   NCH     per-channel cycle
//   wbs_write      in   NCH     1 = write, 0 = read
//   wbs_ack        out  NCH     one-cycle completion pulse per channel
//   wbs_err        out  NCH     one-cycle error pulse (timeout build only, else 0)
//   sdram_addr     out  AW      command address to sdram_ctrl
//   sdram_wr       out  1       write request pulse
//   sdram_rd       out  1       read request pulse
//   sdram_wr_data  out  DW      write data, held until op_done
//   sdram_rd_data  in   DW      read data, valid with op_done
//   sdram_op_done  in   1       operation complete pulse
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, round-robin pointer 0.
// - Request i = wbs_cycle[i] & wbs_strobe[i].
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//     IDLE:  when any request is present, register the grant. Search starts at
//            the pointer, ascending, and wraps from NCH-1 to 0. Latch the
//            address, data and write flag of the granted channel.
//     ISSUE: assert sdram_wr or sdram_rd for exactly 1 cycle.
//     WAIT:  sdram_addr and sdram_wr_data stay stable. On op_done, capture
//            sdram_rd_data (read only).
//     RESP:  pulse wbs_ack[grant] for 1 cycle and drive wbs_readdata[grant].
//            Set pointer = grant+1, with NCH-1 wrapping to 0.
// - Minimum latency is 3 cycles plus the sdram_ctrl latency.
// - wbs_readdata holds its last captured value per channel.
// - A request whose strobe drops after grant still completes at the SDRAM.
//   Its ack is suppressed if cycle & strobe is low in RESP.
// - op_done outside WAIT is ignored.
// - Requests arriving during ISSUE/WAIT/RESP wait. At most one operation is
//   outstanding at a time.
// - A channel that holds its strobe is re-granted only after every other
//   requester has been served once.
// - Asserting reset_n low mid-operation aborts immediately with no ack.
//   sdram_ctrl shares the same reset.
// CONFIGURATION
//   SDRAM_ARB_TIMEOUT_EN defined:
//     - A counter runs in WAIT. If it reaches TIMEOUT without op_done, go to
//       RESP and pulse wbs_err[grant] instead of ack. rd_data is not updated.
//       The pointer still advances.
//     - If op_done and timeout coincide, op_done wins.
//   SDRAM_ARB_TIMEOUT_EN undefined:
//     - WAIT lasts indefinitely, no counter is built, wbs_err ties to 0.
// STRUCTURE
// - sdram_pkg: FSM state localparams and a clog2 function for the grant
//   index width.
// - Sub-module sdram_rr_arbiter (NCH param). Inputs: req vector and pointer.
//   Outputs: one-hot grant, grant index, any_req. Purely combinational.
// - The top file holds the FSM, latches, timeout counter and output muxing.
// TESTING
// 1. Write on ch0 (addr 0x100, data 0xBEEF). Expect one sdram_wr pulse with
//    addr 0x100 and data 0xBEEF, then wbs_ack[0] 1 cycle after op_done.
// 2. Read on ch2. Model returns 0x1234 with op_done. Expect wbs_readdata ch2
//    = 0x1234 and ack[2] together.
// 3. All 4 channels request at once with strobes held. Expect grants in order
//    0,1,2,3, then 0 again (wrap). No channel is served twice before the
//    others.
// 4. Pointer at 3 with only ch1 and ch3 requesting. Expect ch3 granted first,
//    then ch1.
// 5. Drop ch1 strobe during WAIT. Expect one SDRAM op issued and no ack[1].
//    The next requester is granted.
// 6. Timeout build with TIMEOUT=16 and op_done withheld. Expect wbs_err[0]
//    pulsed 16 cycles into WAIT with no ack. Separately, pull reset_n low in
//    WAIT: all outputs drop to 0 asynchronously.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and helpers for the multi-master SDRAM Wishbone arbiter.
// Imported by sdram_rr_arbiter and sdram_wb_arb.
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Ceiling log2, never below one bit so a single-channel build still has an index.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins,
// searching upward and wrapping from NCH-1 to 0.
module sdram_rr_arbiter
    import sdram_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int IW  = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  grant_idx,
    output logic           any_req
);

    always_comb begin
        int c;
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        c         = 0;
        // Walk from the furthest offset back to ptr so the nearest requester is assigned last.
        for (int k = NCH - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NCH) c = c - NCH;
            if (req[c]) begin
                grant     = '0;
                grant[c]  = 1'b1;
                grant_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/sdram_wb_arb.sv
// Round-robin Wishbone front end sharing one sdram_ctrl command port among NCH channels.
// Build macro SDRAM_ARB_TIMEOUT_EN adds an op_done timeout reported on wbs_err.
module sdram_wb_arb
    import sdram_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int AW      = 32,
    parameter int DW      = 16,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH*AW-1:0] wbs_address,
    input  logic [NCH*DW-1:0] wbs_writedata,
    output logic [NCH*DW-1:0] wbs_readdata,
    input  logic [NCH-1:0]    wbs_strobe,
    input  logic [NCH-1:0]    wbs_cycle,
    input  logic [NCH-1:0]    wbs_write,
    output logic [NCH-1:0]    wbs_ack,
    output logic [NCH-1:0]    wbs_err,
    output logic [AW-1:0]     sdram_addr,
    output logic              sdram_wr,
    output logic              sdram_rd,
    output logic [DW-1:0]     sdram_wr_data,
    input  logic [DW-1:0]     sdram_rd_data,
    input  logic              sdram_op_done
);

    localparam int IW = clog2(NCH);

    if (NCH < 1 || NCH > 16 || TIMEOUT < 1) begin : g_bad_params
        $error("sdram_wb_arb: NCH must be 1..16 and TIMEOUT at least 1");
    end

    arb_state_t               state_reg, state_next;
    logic [IW-1:0]            ptr_reg;
    logic [IW-1:0]            grant_idx_reg;
    logic [NCH-1:0]           grant_reg;
    logic [AW-1:0]            addr_reg;
    logic [DW-1:0]            wdata_reg;
    logic                     write_reg;
    logic [NCH-1:0][DW-1:0]   rdata_reg;

    logic [NCH-1:0]           req;
    logic [NCH-1:0]           arb_grant;
    logic [IW-1:0]            arb_idx;
    logic                     any_req;
    logic [AW-1:0]            addr_ch  [NCH];
    logic [DW-1:0]            wdata_ch [NCH];
    logic                     tmo_hit;
    logic                     resp_err;

    assign req = wbs_cycle & wbs_strobe;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign addr_ch[gi]  = wbs_address[gi*AW +: AW];
        assign wdata_ch[gi] = wbs_writedata[gi*DW +: DW];
    end

    sdram_rr_arbiter #(
        .NCH (NCH)
    ) u_arbiter (
        .req       (req),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_reg;
    logic          tmo_flag_reg;

    // op_done takes priority over an expiring counter in the same cycle.
    assign tmo_hit  = (state_reg == ST_WAIT) && !sdram_op_done && (tmo_cnt_reg == TW'(TIMEOUT - 1));
    assign resp_err = tmo_flag_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_reg  <= '0;
            tmo_flag_reg <= 1'b0;
        end else if (state_reg == ST_WAIT) begin
            tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
            tmo_flag_reg <= tmo_hit;
        end else begin
            tmo_cnt_reg  <= '0;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (any_req) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (sdram_op_done || tmo_hit) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg       <= '0;
            grant_idx_reg <= '0;
            grant_reg     <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            write_reg     <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            if (state_reg == ST_IDLE && any_req) begin
                grant_idx_reg <= arb_idx;
                grant_reg     <= arb_grant;
                addr_reg      <= addr_ch[arb_idx];
                wdata_reg     <= wdata_ch[arb_idx];
                write_reg     <= wbs_write[arb_idx];
            end
            if (state_reg == ST_WAIT && sdram_op_done && !write_reg) begin
                rdata_reg[grant_idx_reg] <= sdram_rd_data;
            end
            if (state_reg == ST_RESP) begin
                ptr_reg <= (grant_idx_reg == IW'(NCH - 1)) ? '0 : grant_idx_reg + 1'b1;
            end
        end
    end

    // A master that abandoned its request after grant gets no completion pulse.
    assign wbs_ack       = (state_reg == ST_RESP && !resp_err) ? (grant_reg & req) : '0;
    assign wbs_err       = (state_reg == ST_RESP &&  resp_err) ? (grant_reg & req) : '0;
    assign wbs_readdata  = rdata_reg;
    assign sdram_wr      = (state_reg == ST_ISSUE) &&  write_reg;
    assign sdram_rd      = (state_reg == ST_ISSUE) && !write_reg;
    assign sdram_addr    = addr_reg;
    assign sdram_wr_data = wdata_reg;

endmodule

// File: tb/tb_sdram_wb_arb.sv
// Scoreboard bench for sdram_wb_arb: a responder model checks SDRAM commands,
// a monitor checks Wishbone completions; stimulus only queues expectations.
module tb_sdram_wb_arb;

    localparam int NCH     = 4;
    localparam int AW      = 32;
    localparam int DW      = 16;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH*AW-1:0] wbs_address = '0;
    logic [NCH*DW-1:0] wbs_writedata = '0;
    logic [NCH*DW-1:0] wbs_readdata;
    logic [NCH-1:0]    wbs_strobe = '0;
    logic [NCH-1:0]    wbs_cycle = '0;
    logic [NCH-1:0]    wbs_write = '0;
    logic [NCH-1:0]    wbs_ack;
    logic [NCH-1:0]    wbs_err;
    logic [AW-1:0]     sdram_addr;
    logic              sdram_wr;
    logic              sdram_rd;
    logic [DW-1:0]     sdram_wr_data;
    logic [DW-1:0]     sdram_rd_data = '0;
    logic              sdram_op_done = 1'b0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            ch;
        logic          err;
        logic          chk_rd;
        logic [DW-1:0] rdata;
    } rsp_t;

    cmd_t          cmd_q[$];
    rsp_t          rsp_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          hold_done = 1'b0;
    logic          prev_done = 1'b0;
    int            checks = 0;
    int            errors = 0;

    sdram_wb_arb #(
        .NCH     (NCH),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wbs_address   (wbs_address),
        .wbs_writedata (wbs_writedata),
        .wbs_readdata  (wbs_readdata),
        .wbs_strobe    (wbs_strobe),
        .wbs_cycle     (wbs_cycle),
        .wbs_write     (wbs_write),
        .wbs_ack       (wbs_ack),
        .wbs_err       (wbs_err),
        .sdram_addr    (sdram_addr),
        .sdram_wr      (sdram_wr),
        .sdram_rd      (sdram_rd),
        .sdram_wr_data (sdram_wr_data),
        .sdram_rd_data (sdram_rd_data),
        .sdram_op_done (sdram_op_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic exp_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.data = d;
        cmd_q.push_back(c);
    endtask

    task automatic exp_rsp(input int ch, input logic err, input logic chk, input logic [DW-1:0] rd);
        rsp_t r;
        r.ch = ch; r.err = err; r.chk_rd = chk; r.rdata = rd;
        rsp_q.push_back(r);
    endtask

    task automatic set_ch(input int ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wbs_address[ch*AW +: AW]   = a;
        wbs_writedata[ch*DW +: DW] = d;
        wbs_write[ch]              = we;
    endtask

    // Hold the channels in mask until nrsp completions have been seen, then release them.
    task automatic run(input logic [NCH-1:0] mask, input int nrsp, input int budget);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        wbs_cycle  = mask;
        wbs_strobe = mask;
        while (seen < nrsp && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
            if (((wbs_ack | wbs_err) & mask) != '0) seen++;
        end
        if (seen < nrsp) begin
            checks++; errors++;
            $display("FAIL rsp_wait seen %0d required %0d", seen, nrsp);
        end
        wbs_cycle  = '0;
        wbs_strobe = '0;
    endtask

    task automatic wait_cmd();
        int ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (sdram_wr || sdram_rd) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            checks++; errors++;
            $display("FAIL cmd_wait actual none required command");
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    // SDRAM responder: checks each issued command, answers after LAT cycles unless held off.
    initial begin
        logic [AW-1:0] a;
        logic          rd;
        cmd_t          c;
        forever begin
            @(negedge clk);
            if (reset_n && (sdram_wr || sdram_rd)) begin
                a  = sdram_addr;
                rd = sdram_rd;
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd actual addr %0h required none", sdram_addr);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_write", sdram_wr, c.we);
                    check("cmd_read", sdram_rd, !c.we);
                    check("cmd_addr", sdram_addr, c.addr);
                    if (c.we) check("cmd_wdata", sdram_wr_data, c.data);
                end
                if (sdram_wr) mem[sdram_addr] = sdram_wr_data;
                $display("cmd %s addr %0h wdata %0h t=%0t", rd ? "RD" : "WR", a, sdram_wr_data, $time);
                if (!hold_done) begin
                    repeat (LAT) @(posedge clk);
                    #1;
                    sdram_op_done = 1'b1;
                    sdram_rd_data = (rd && mem.exists(a)) ? mem[a] : '0;
                    @(posedge clk); #1;
                    sdram_op_done = 1'b0;
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        rsp_t           e;
        logic [NCH-1:0] onehot;
        forever begin
            @(negedge clk);
            if ((wbs_ack | wbs_err) != '0) begin
                $display("rsp ack %b err %b rdata %h t=%0t", wbs_ack, wbs_err, wbs_readdata, $time);
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual ack %b err %b required none", wbs_ack, wbs_err);
                end else begin
                    e = rsp_q.pop_front();
                    onehot = '0;
                    onehot[e.ch] = 1'b1;
                    check("rsp_ack", wbs_ack, e.err ? '0 : onehot);
                    check("rsp_err", wbs_err, e.err ? onehot : '0);
                    check("rsp_after_done", prev_done, !e.err);
                    if (e.chk_rd) check("rsp_rdata", wbs_readdata[e.ch*DW +: DW], e.rdata);
                end
            end
            prev_done = sdram_op_done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[32'h200] = 16'h1234;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ack", wbs_ack, '0);
        check("rst_err", wbs_err, '0);
        check("rst_wr", sdram_wr, 1'b0);
        check("rst_rd", sdram_rd, 1'b0);
        check("rst_addr", sdram_addr, '0);
        check("rst_wdata", sdram_wr_data, '0);
        check("rst_rdata", wbs_readdata, '0);
        #1 reset_n = 1'b1;

        // Single write on ch0.
        set_ch(0, 1'b1, 32'h100, 16'hBEEF);
        exp_cmd(1'b1, 32'h100, 16'hBEEF);
        exp_rsp(0, 1'b0, 1'b0, '0);
        run(4'b0001, 1, 100);

        // Read on ch2 returns the stored 0x1234; pointer moves to 3.
        set_ch(2, 1'b0, 32'h200, 16'h0000);
        exp_cmd(1'b0, 32'h200, '0);
        exp_rsp(2, 1'b0, 1'b1, 16'h1234);
        run(4'b0100, 1, 100);

        // Pointer at 3 with ch1 and ch3 requesting: ch3 first, then ch1.
        set_ch(1, 1'b1, 32'h300, 16'h3131);
        set_ch(3, 1'b1, 32'h400, 16'h4343);
        exp_cmd(1'b1, 32'h400, 16'h4343);
        exp_cmd(1'b1, 32'h300, 16'h3131);
        exp_rsp(3, 1'b0, 1'b0, '0);
        exp_rsp(1, 1'b0, 1'b0, '0);
        run(4'b1010, 2, 200);

        // All channels held from pointer 0: 0,1,2,3 then 0 again.
        pulse_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            set_ch(ch, 1'b1, AW'(32'h100 + ch * 16), DW'(16'hA0A0 + ch * 16'h0101));
        end
        for (int n = 0; n < 5; n++) begin
            exp_cmd(1'b1, AW'(32'h100 + (n % NCH) * 16), DW'(16'hA0A0 + (n % NCH) * 16'h0101));
            exp_rsp(n % NCH, 1'b0, 1'b0, '0);
        end
        run(4'b1111, 5, 400);

        // ch1 drops out during WAIT: its op completes silently, then ch2 is served.
        set_ch(1, 1'b1, 32'h500, 16'h5151);
        set_ch(2, 1'b1, 32'h600, 16'h6262);
        exp_cmd(1'b1, 32'h500, 16'h5151);
        exp_cmd(1'b1, 32'h600, 16'h6262);
        exp_rsp(2, 1'b0, 1'b0, '0);
        wbs_cycle  = 4'b0110;
        wbs_strobe = 4'b0110;
        wait_cmd();
        @(negedge clk); #1;
        wbs_cycle[1]  = 1'b0;
        wbs_strobe[1] = 1'b0;
        run(4'b0100, 1, 100);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // op_done withheld: err arrives after TIMEOUT cycles of WAIT, no ack.
        begin
            int cyc;
            pulse_reset();
            hold_done = 1'b1;
            set_ch(0, 1'b1, 32'h800, 16'h8888);
            exp_cmd(1'b1, 32'h800, 16'h8888);
            exp_rsp(0, 1'b1, 1'b0, '0);
            wbs_cycle  = 4'b0001;
            wbs_strobe = 4'b0001;
            wait_cmd();
            cyc = 0;
            while (wbs_err[0] !== 1'b1 && cyc < 100) begin
                @(negedge clk); #1;
                cyc++;
            end
            check("timeout_cycles", 64'(cyc), 64'(TIMEOUT + 1));
            wbs_cycle  = '0;
            wbs_strobe = '0;
            @(negedge clk); #1;
            hold_done = 1'b0;
        end
`endif

        // Reset pulled mid-WAIT: every output falls without waiting for a clock.
        hold_done = 1'b1;
        set_ch(0, 1'b1, 32'h700, 16'h7777);
        exp_cmd(1'b1, 32'h700, 16'h7777);
        wbs_cycle  = 4'b0001;
        wbs_strobe = 4'b0001;
        wait_cmd();
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_ack", wbs_ack, '0);
        check("abort_err", wbs_err, '0);
        check("abort_wr", sdram_wr, 1'b0);
        check("abort_rd", sdram_rd, 1'b0);
        check("abort_addr", sdram_addr, '0);
        check("abort_wdata", sdram_wr_data, '0);
        check("abort_rdata", wbs_readdata, '0);
        wbs_cycle  = '0;
        wbs_strobe = '0;
        @(negedge clk); #1;
        reset_n   = 1'b1;
        hold_done = 1'b0;

        // Normal operation resumes; earlier read data on ch0 is held while ch2 reads.
        set_ch(0, 1'b0, 32'h100, '0);
        exp_cmd(1'b0, 32'h100, '0);
        exp_rsp(0, 1'b0, 1'b1, 16'hA0A0);
        run(4'b0001, 1, 100);
        set_ch(2, 1'b0, 32'h200, '0);
        exp_cmd(1'b0, 32'h200, '0);
        exp_rsp(2, 1'b0, 1'b1, 16'h1234);
        run(4'b0100, 1, 100);
        repeat (3) @(negedge clk);
        check("hold_rdata_ch0", wbs_readdata[0 +: DW], 16'hA0A0);
        check("idle_ack", wbs_ack, '0);
        check("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);
        check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
